// File: rtl/reg4_write_arbiter_pkg.sv
// ============================================================================
// Module  : reg_arb_pkg
// Purpose : Shared defaults and index helpers for the round-robin write
//           arbiter and its combinational picker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

  // Default requester count and register width.
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 4;

  // Width of an index into n requesters. This is never less than one bit,
  // so a degenerate n still yields a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wrapped increment: idx+1, returning to 0 after n-1.
  // The explicit compare keeps the wrap correct when n is not a power of two.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage : reg_arb_pkg

`default_nettype wire

// File: rtl/reg4_write_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin picker. Finds the first set bit of the
//           eligible vector, searching upward from the pointer with
//           wrap-around. It carries no state, so other arbiters can reuse it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int IW = idx_w(NUM_REQ_DEF)
) (
  input  logic [N-1:0]  e_i,    // eligible requesters
  input  logic [IW-1:0] ptr_i,  // highest-priority index this cycle
  output logic [IW-1:0] win_o,  // winning index (0 when none eligible)
  output logic          any_o   // at least one requester eligible
);

  // One spare bit so ptr + offset never overflows before the wrap subtract.
  localparam int KW = IW + 1;

  // Walk the N candidates in priority order and keep the first eligible one.
  always_comb begin
    logic [KW-1:0] k;
    k     = '0;
    win_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = {1'b0, ptr_i} + KW'(i);
      if (k >= KW'(N)) begin
        k = k - KW'(N);
      end
      if (!any_o && e_i[k[IW-1:0]]) begin
        any_o = 1'b1;
        win_o = k[IW-1:0];
      end
    end
  end

endmodule : rr_pick

`default_nettype wire

// File: rtl/reg4_write_arbiter.sv
// ============================================================================
// Module  : reg4_write_arbiter
// Purpose : Round-robin write arbiter in front of one shared DATA_W-bit
//           register. At most one requester writes per cycle. The write is
//           acknowledged by a registered one-cycle Gnt pulse. A requester
//           granted this cycle is masked, so dropping Req in its Gnt cycle
//           cannot cause a second write.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg4_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                          Clk,
  input  logic                          Rst_l,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [NUM_REQ*DATA_W-1:0]     Wdata,
  output logic [NUM_REQ-1:0]            Gnt,
  output logic [DATA_W-1:0]             Q,
  output logic [idx_w(NUM_REQ)-1:0]     Owner,
  output logic                          Valid
);

  localparam int IDX_W = idx_w(NUM_REQ);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [DATA_W-1:0]  q_q,     q_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               valid_q, valid_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0] elig_w;
  logic [IDX_W-1:0]   win_w;
  logic               any_w;
  logic [DATA_W-1:0]  lane_w [NUM_REQ];
  logic [DATA_W-1:0]  wsel_w;

  // A requester holding Gnt this cycle is excluded from the next pick.
  assign elig_w = Req & ~gnt_q;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_pick (
    .e_i   (elig_w),
    .ptr_i (ptr_q),
    .win_o (win_w),
    .any_o (any_w)
  );

  // Split the flat write-data bus into per-requester lanes.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lanes
    assign lane_w[g] = Wdata[g*DATA_W +: DATA_W];
  end

  assign wsel_w = lane_w[win_w];

  // Next-state: on a winner, load its lane and advance the pointer past it.
  // With no winner, only the grant clears.
  always_comb begin
    ptr_d   = ptr_q;
    gnt_d   = '0;
    q_d     = q_q;
    owner_d = owner_q;
    valid_d = valid_q;
    if (any_w) begin
      gnt_d[win_w] = 1'b1;
      q_d          = wsel_w;
      owner_d      = win_w;
      valid_d      = 1'b1;
      ptr_d        = IDX_W'(rr_next(int'(win_w), NUM_REQ));
    end
  end

  // State registers. The synchronous active-low reset overrides any write.
  always_ff @(posedge Clk) begin
    if (!Rst_l) begin
      ptr_q   <= '0;
      gnt_q   <= '0;
      q_q     <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs come straight from the registers, with no combinational path.
  // --------------------------------------------------------------------------
  assign Gnt   = gnt_q;
  assign Q     = q_q;
  assign Owner = owner_q;
  assign Valid = valid_q;

endmodule : reg4_write_arbiter

`default_nettype wire

// File: tb/tb_reg4_write_arbiter.sv
// ============================================================================
// Module  : tb_reg4_write_arbiter
// Purpose : Directed self-checking bench for reg4_write_arbiter (4 x 4-bit).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg4_write_arbiter;

  logic        Clk;
  logic        Rst_l;
  logic [3:0]  Req;
  logic [15:0] Wdata;
  logic [3:0]  Gnt;
  logic [3:0]  Q;
  logic [1:0]  Owner;
  logic        Valid;

  int compared;
  int mismatched;

  reg4_write_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (4)
  ) dut (
    .Clk   (Clk),
    .Rst_l (Rst_l),
    .Req   (Req),
    .Wdata (Wdata),
    .Gnt   (Gnt),
    .Q     (Q),
    .Owner (Owner),
    .Valid (Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge, then settle 1 time unit before sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst_l = 1'b0;
    Req   = 4'b1111;
    Wdata = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      compared++;
      if (Q !== 4'h0 || Gnt !== 4'b0000 || Valid !== 1'b0 || Owner !== 2'd0) begin
        mismatched++;
        $display("FAIL reset_hold[%0d]: Q=%h Gnt=%b Valid=%b Owner=%0d, need Q=0 Gnt=0000 Valid=0 Owner=0",
                 c, Q, Gnt, Valid, Owner);
      end
    end
    Rst_l = 1'b1;
    tick();
    compared++;
    if (Gnt !== 4'b0001 || Q !== 4'hF || Valid !== 1'b1 || Owner !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_release: Gnt=%b Q=%h Valid=%b Owner=%0d, need Gnt=0001 Q=f Valid=1 Owner=0",
               Gnt, Q, Valid, Owner);
    end
    Req = 4'b0000;
    tick();
    compared++;
    if (Gnt !== 4'b0000 || Q !== 4'hF) begin
      mismatched++;
      $display("FAIL reset_idle: Gnt=%b Q=%h, need Gnt=0000 Q=f", Gnt, Q);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_g [4];
    exp_g = '{4'b0100, 4'b0000, 4'b0100, 4'b0000};
    Req   = 4'b0100;
    Wdata = 16'h0A00;
    for (int c = 0; c < 4; c++) begin
      tick();
      compared++;
      if (Gnt !== exp_g[c] || Q !== 4'hA || Owner !== 2'd2 || Valid !== 1'b1) begin
        mismatched++;
        $display("FAIL single[%0d]: Gnt=%b Q=%h Owner=%0d Valid=%b, need Gnt=%b Q=a Owner=2 Valid=1",
                 c, Gnt, Q, Owner, Valid, exp_g[c]);
      end
    end
    Req = 4'b0000;
    tick();
  endtask

  task automatic test_contention();
    logic [3:0] exp_g [5];
    logic [3:0] exp_q [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    // Reset to return the pointer to 0.
    Rst_l = 1'b0;
    Req   = 4'b0000;
    tick();
    Rst_l = 1'b1;
    Req   = 4'b1111;
    Wdata = 16'h4321;
    for (int c = 0; c < 5; c++) begin
      tick();
      compared++;
      if (Gnt !== exp_g[c] || Q !== exp_q[c]) begin
        mismatched++;
        $display("FAIL contention[%0d]: Gnt=%b Q=%h, need Gnt=%b Q=%h",
                 c, Gnt, Q, exp_g[c], exp_q[c]);
      end
    end
    Req = 4'b0000;
    tick();
  endtask

  task automatic test_wrap();
    logic [3:0] exp_g [3];
    logic [3:0] exp_q [3];
    logic [1:0] exp_o [3];
    exp_g = '{4'b0001, 4'b1000, 4'b0001};
    exp_q = '{4'h1, 4'h4, 4'h1};
    exp_o = '{2'd0, 2'd3, 2'd0};
    Wdata = 16'h4321;
    Req   = 4'b1000;
    tick();
    compared++;
    if (Gnt !== 4'b1000 || Q !== 4'h4 || Owner !== 2'd3) begin
      mismatched++;
      $display("FAIL wrap_grant3: Gnt=%b Q=%h Owner=%0d, need Gnt=1000 Q=4 Owner=3", Gnt, Q, Owner);
    end
    Req = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      tick();
      compared++;
      if (Gnt !== exp_g[c] || Q !== exp_q[c] || Owner !== exp_o[c]) begin
        mismatched++;
        $display("FAIL wrap[%0d]: Gnt=%b Q=%h Owner=%0d, need Gnt=%b Q=%h Owner=%0d",
                 c, Gnt, Q, Owner, exp_g[c], exp_q[c], exp_o[c]);
      end
    end
    Req = 4'b0000;
    tick();
    compared++;
    if (Gnt !== 4'b0000) begin
      mismatched++;
      $display("FAIL wrap_idle: Gnt=%b, need 0000", Gnt);
    end
  endtask

  task automatic test_withdraw_and_reset();
    Wdata = 16'h0097;
    Req   = 4'b0001;
    tick();
    compared++;
    if (Gnt !== 4'b0001 || Q !== 4'h7 || Owner !== 2'd0) begin
      mismatched++;
      $display("FAIL withdraw_grant0: Gnt=%b Q=%h Owner=%0d, need Gnt=0001 Q=7 Owner=0", Gnt, Q, Owner);
    end
    // Requester 1 pulses Req between edges; requester 0 finishes.
    Req = 4'b0010;
    #3;
    Req = 4'b0000;
    tick();
    compared++;
    if (Gnt !== 4'b0000 || Q !== 4'h7 || Owner !== 2'd0) begin
      mismatched++;
      $display("FAIL withdraw: Gnt=%b Q=%h Owner=%0d, need Gnt=0000 Q=7 Owner=0", Gnt, Q, Owner);
    end
    // Reset asserted in the same cycle as a new request.
    Rst_l = 1'b0;
    Req   = 4'b0010;
    tick();
    compared++;
    if (Gnt !== 4'b0000 || Q !== 4'h0 || Valid !== 1'b0 || Owner !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_vs_req: Gnt=%b Q=%h Valid=%b Owner=%0d, need Gnt=0000 Q=0 Valid=0 Owner=0",
               Gnt, Q, Valid, Owner);
    end
    Rst_l = 1'b1;
    tick();
    compared++;
    if (Gnt !== 4'b0010 || Q !== 4'h9 || Owner !== 2'd1 || Valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rearb_after_reset: Gnt=%b Q=%h Owner=%0d Valid=%b, need Gnt=0010 Q=9 Owner=1 Valid=1",
               Gnt, Q, Owner, Valid);
    end
    // A Gnt that is high in a reset cycle is cleared on that edge.
    Rst_l = 1'b0;
    tick();
    compared++;
    if (Gnt !== 4'b0000 || Q !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_mid_gnt: Gnt=%b Q=%h, need Gnt=0000 Q=0", Gnt, Q);
    end
    Rst_l = 1'b1;
    Req   = 4'b0000;
    tick();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    Rst_l      = 1'b0;
    Req        = 4'b0000;
    Wdata      = 16'h0000;
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_withdraw_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_reg4_write_arbiter

`default_nettype wire

// File: doc/reg4_write_arbiter.md
# reg4_write_arbiter

Round-robin write arbiter that shares one DATA_W-bit storage register between NUM_REQ requesters. Each cycle it selects at most one pending requester, loads that requester's data into the shared register, and returns a one-cycle grant pulse as the write acknowledge. It sits in front of the shared state register in the datapath. It replaces ad-hoc muxing when several agents must update the same register without collisions or starvation.

## Interface
- NUM_REQ, default 4: number of requesters, range 2..8.
- DATA_W, default 4: width of the shared register and of each write-data lane.
- Clk  input  1: single clock; all state updates on rising edge.
- Rst_l  input  1: reset, synchronous and active-low. Sampled on the rising edge of Clk; no asynchronous path.
- Req  input  NUM_REQ: per-requester write request, level-sensitive.
- Wdata  input  NUM_REQ*DATA_W: write data; lane i is bits [i*DATA_W +: DATA_W].
- Gnt  output  NUM_REQ: registered, one-hot or zero, one-cycle write acknowledge.
- Q  output  DATA_W: shared register contents.
- Owner  output  $clog2(NUM_REQ): index of the last requester written.
- Valid  output  1: high once any write has occurred since reset.

## Operation
- **Reset** (Rst_l low at a rising edge, dominates all else):
  - Q=0, Gnt=0, Owner=0, Valid=0.
  - Internal round-robin pointer Ptr=0.
- **Eligible set:** E = Req & ~Gnt.
  - A requester whose Gnt is high this cycle is masked.
  - This prevents a double write while it drops Req.
- **Winner:** first set bit of E, searching from index Ptr upward with wrap-around: Ptr, Ptr+1, …, NUM_REQ-1, 0, …, Ptr-1.
- **If E nonzero, at the edge:**
  - Q <= Wdata lane W.
  - Gnt <= one-hot(W).
  - Owner <= W.
  - Valid <= 1.
  - Ptr <= (W+1) mod NUM_REQ.
- **If E is zero:** Gnt <= 0. Q, Owner, Valid and Ptr hold.
- **Requester protocol:**
  - Assert Req with Wdata stable and hold both until Gnt is seen high.
  - Deassert Req in the Gnt cycle to finish; keeping it high requests another write.
  - Wdata is sampled only at the granting edge.
- **Req dropped before grant:** the request is withdrawn; no write occurs and no error is flagged.
- **Fairness:** with all requesters permanently asserting, grants rotate strictly 0,1,…,NUM_REQ-1,0,… Worst-case wait is NUM_REQ cycles.
- **Width rule:** Ptr and Owner are $clog2(NUM_REQ) bits. Wrap uses an explicit compare with NUM_REQ-1, so it is correct for non-power-of-two NUM_REQ.

## Timing
- Request to write: Req high before edge N gives Q updated and Gnt high during cycle N+1. Latency is 1 cycle when uncontended.
- Throughput: one write per cycle across requesters. A single requester writes at most every 2 cycles because of Gnt masking.
- All outputs are registered; there is no combinational path from Req or Wdata to any output.
- Simultaneous reset and request: reset wins. No Gnt is issued, and the request is re-arbitrated from Ptr=0 after reset releases.
- Reset mid-transaction: a Gnt high in the reset cycle is cleared on that edge. The requester must not count a Gnt that was not observed high.

## Structure
- Package reg_arb_pkg holds:
  - parameters NUM_REQ_DEF=4 and DATA_W_DEF=4;
  - the localparam idx width function;
  - function rr_next(idx, n) for the wrapped increment.
- One sub-module, rr_pick: purely combinational.
  - Inputs: E, Ptr.
  - Outputs: winner index and any_valid.
  - Reusable by other arbiters.
- Top level holds the Ptr, Gnt, Q, Owner and Valid registers and the Wdata lane mux.

## Test plan
- **Reset:** drive Req=4'b1111 and Wdata=16'hFFFF, hold Rst_l=0 for 3 cycles -> Q=0, Gnt=0, Valid=0, Owner=0 throughout. Release -> first Gnt=4'b0001 with Q=4'hF.
- **Single requester:** Req=4'b0100, lane2=4'hA, held 4 cycles -> Gnt alternates 0100, 0000, 0100, 0000; Q=4'hA; Owner=2; Valid=1.
- **Full contention:** Req=4'b1111 with lanes 3..0 = 4'h4,4'h3,4'h2,4'h1 -> Gnt sequence 0001, 0010, 0100, 1000, 0001; Q sequence 1,2,3,4,1.
- **Pointer wrap and fairness:** after a grant to requester 3, Req=4'b1001 -> next Gnt=0001, then 1000. No requester waits more than 4 cycles.
- **Withdrawal and simultaneous events:** requester 1 raises and drops Req while requester 0 is being granted -> requester 1 gets no Gnt and Q is unchanged by it. Then assert Rst_l=0 in the same cycle as a new Req -> no write, and Q=0 after the edge.
